// File: rtl/my_sdram_frontend.sv
// Host-side front end for an SDRAM controller: buffered writes, one outstanding read,
// starvation-limited read priority. Define MY_SDRAM_FRONTEND_STATS_EN for grant counters.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | choose between an accepted host read and a buffered write
// S_WR_REQ  | write_req up with FIFO head on w_addr/din, wait write_gnt
// S_RD_REQ  | read_req up with captured address, wait read_gnt
// S_RD_DATA | wait read_valid, capture dout into rsp_data
// S_GNT_LOW | wait for both grants low so a held grant is never reused
module my_sdram_frontend #(
    parameter int WFIFO_DEPTH = 4,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [19:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [19:0] rd_addr,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        write_req,
    output logic [19:0] w_addr,
    output logic [15:0] din,
    input  logic        write_gnt,
    output logic        read_req,
    output logic [19:0] r_addr,
    input  logic        read_gnt,
    input  logic [15:0] dout,
    input  logic        read_valid,
    input  logic        busy,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_rd
);

    localparam int PTR_W    = $clog2(WFIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_DATA = 3'd3,
        S_GNT_LOW = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [35:0]          r_mem [WFIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [STARVE_W-1:0]  r_starve_cnt;
    logic                 r_init_done;
    logic                 r_rsp_valid;
    logic [15:0]          r_rsp_data;
    logic [19:0]          r_w_addr;
    logic [15:0]          r_din;
    logic [19:0]          r_r_addr;

    logic                 w_fifo_nempty;
    logic                 w_fifo_full;
    logic                 w_wr_wins;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_gnt;
    logic                 w_rd_accept;
    logic                 w_write_req;
    logic                 w_read_req;
    logic                 w_rd_ready;
    logic [35:0]          w_head;

    assign w_fifo_nempty = (r_count != '0);
    assign w_fifo_full   = (r_count == CNT_W'(WFIFO_DEPTH));
    assign w_wr_wins     = w_fifo_nempty &&
                           (w_fifo_full || (r_starve_cnt == STARVE_W'(STARVE_MAX)));
    assign w_push        = wr_valid && !w_fifo_full;
    assign w_pop         = (r_state == S_WR_REQ) && write_gnt;
    assign w_rd_gnt      = (r_state == S_RD_REQ) && read_gnt;
    assign w_rd_accept   = rd_valid && w_rd_ready;
    assign w_head        = r_mem[r_rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rd_accept) begin
                    w_next = S_RD_REQ;
                end else if (w_fifo_nempty && r_init_done) begin
                    w_next = S_WR_REQ;
                end
            end
            S_WR_REQ:  if (write_gnt)  w_next = S_GNT_LOW;
            S_RD_REQ:  if (read_gnt)   w_next = S_RD_DATA;
            S_RD_DATA: if (read_valid) w_next = S_GNT_LOW;
            S_GNT_LOW: if (!write_gnt && !read_gnt) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_write_req = 1'b0;
        w_read_req  = 1'b0;
        w_rd_ready  = 1'b0;
        case (r_state)
            S_IDLE:   w_rd_ready  = r_init_done && !r_rsp_valid && !w_wr_wins;
            S_WR_REQ: w_write_req = 1'b1;
            S_RD_REQ: w_read_req  = 1'b1;
            default:  ;
        endcase
    end

    assign write_req = w_write_req;
    assign read_req  = w_read_req;
    assign rd_ready  = w_rd_ready;
    assign wr_ready  = !w_fifo_full;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign w_addr    = r_w_addr;
    assign din       = r_din;
    assign r_addr    = r_r_addr;

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_pop || !w_fifo_nempty) begin
            r_starve_cnt <= '0;
        end else if (w_rd_gnt && (r_starve_cnt != STARVE_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_w_addr    <= '0;
            r_din       <= '0;
            r_r_addr    <= '0;
        end else begin
            r_init_done <= r_init_done || !busy;
            r_rsp_valid <= (r_state == S_RD_DATA) && read_valid;
            if ((r_state == S_RD_DATA) && read_valid) begin
                r_rsp_data <= dout;
            end
            if ((r_state == S_IDLE) && (w_next == S_WR_REQ)) begin
                r_w_addr <= w_head[35:16];
                r_din    <= w_head[15:0];
            end
            if (w_rd_accept) begin
                r_r_addr <= rd_addr;
            end
        end
    end

`ifdef MY_SDRAM_FRONTEND_STATS_EN
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_wr <= '0;
            r_stat_rd <= '0;
        end else begin
            if (w_pop && (r_stat_wr != 16'hFFFF))    r_stat_wr <= r_stat_wr + 16'd1;
            if (w_rd_gnt && (r_stat_rd != 16'hFFFF)) r_stat_rd <= r_stat_rd + 16'd1;
        end
    end

    assign stat_wr = r_stat_wr;
    assign stat_rd = r_stat_rd;
`else
    assign stat_wr = '0;
    assign stat_rd = '0;
`endif

endmodule

// File: tb/tb_my_sdram_frontend.sv
// Directed bench for my_sdram_frontend with a behavioural SDRAM controller responder.
// Stats expectations follow MY_SDRAM_FRONTEND_STATS_EN.
module tb_my_sdram_frontend;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [19:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [19:0] rd_addr = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        write_req;
    logic [19:0] w_addr;
    logic [15:0] din;
    logic        write_gnt = 1'b0;
    logic        read_req;
    logic [19:0] r_addr;
    logic        read_gnt = 1'b0;
    logic [15:0] dout = '0;
    logic        read_valid = 1'b0;
    logic        busy = 1'b1;
    logic [15:0] stat_wr;
    logic [15:0] stat_rd;

    int n_tests = 0;
    int n_fail  = 0;

    int rd_gnt_dly = 2;
    int rd_lat     = 2;
    int wr_gnt_dly = 2;
    int wr_hold    = 1;
    logic [15:0] rd_dout_val = 16'h0000;

    logic [35:0] wlog [$];
    logic [19:0] last_raddr = '0;
    logic [15:0] last_rsp = '0;
    int n_wr_gnt = 0;
    int n_rd_gnt = 0;
    int n_stale = 0;
    int n_both = 0;
    int n_wreq_cyc = 0;
    int n_rsp = 0;

    always #5 clk = ~clk;

    my_sdram_frontend dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .write_req  (write_req),
        .w_addr     (w_addr),
        .din        (din),
        .write_gnt  (write_gnt),
        .read_req   (read_req),
        .r_addr     (r_addr),
        .read_gnt   (read_gnt),
        .dout       (dout),
        .read_valid (read_valid),
        .busy       (busy),
        .stat_wr    (stat_wr),
        .stat_rd    (stat_rd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model: grants after a programmable delay, holds write grant wr_hold cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (read_req) begin
                repeat (rd_gnt_dly - 1) @(negedge clk);
                if (read_req) begin
                    n_rd_gnt++;
                    last_raddr = r_addr;
                end
                read_gnt = 1'b1;
                @(negedge clk);
                read_gnt = 1'b0;
                repeat (rd_lat - 1) @(negedge clk);
                dout = rd_dout_val;
                read_valid = 1'b1;
                @(negedge clk);
                read_valid = 1'b0;
            end else if (write_req) begin
                repeat (wr_gnt_dly - 1) @(negedge clk);
                if (write_req) begin
                    n_wr_gnt++;
                    wlog.push_back({w_addr, din});
                end
                write_gnt = 1'b1;
                repeat (wr_hold) begin
                    @(negedge clk);
                    if (write_req) n_stale++;
                end
                write_gnt = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (write_req && read_req) n_both++;
        if (write_req) n_wreq_cyc++;
        if (rsp_valid) begin
            n_rsp++;
            last_rsp = rsp_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push(input logic [19:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [19:0] a);
        bit acc = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = a;
        for (int i = 0; i < 60; i++) begin
            if (rd_ready) begin
                @(negedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rd_valid = 1'b0;
        check("rd_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_wr(input int target, input string tag);
        int i = 0;
        while (n_wr_gnt < target && i < 300) begin
            @(negedge clk);
            i++;
        end
        check(tag, 64'(n_wr_gnt >= target), 64'd1);
    endtask

    initial begin
        int n_early;
        int wb, rb, rg0, wg0, st0, rs0, ws0, i;
        bit seen;
        logic [15:0] exp_wr, exp_rd;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_write_req", 64'(write_req), 64'd0);
        check("rst_read_req",  64'(read_req),  64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        check("rst_w_addr",    64'(w_addr),    64'd0);
        check("rst_din",       64'(din),       64'd0);
        check("rst_r_addr",    64'(r_addr),    64'd0);
        check("rst_stat_wr",   64'(stat_wr),   64'd0);
        check("rst_stat_rd",   64'(stat_rd),   64'd0);
        check("rst_wr_ready",  64'(wr_ready),  64'd1);
        check("rst_rd_ready",  64'(rd_ready),  64'd0);

        // Release with busy high for 10 cycles; a write pushed meanwhile must wait
        reset_n = 1'b1;
        n_early = 0;
        for (int k = 0; k < 10; k++) begin
            wr_valid = (k == 2);
            wr_addr  = 20'h00001;
            wr_data  = 16'h5555;
            @(negedge clk);
            if (k == 0) check("wr_ready_after_release", 64'(wr_ready), 64'd1);
            if (rd_ready || write_req || read_req) n_early++;
        end
        wr_valid = 1'b0;
        busy = 1'b0;
        check("init_no_early_activity", 64'(n_early), 64'd0);
        check("init_rd_ready_low", 64'(rd_ready), 64'd0);
        @(negedge clk);
        check("init_rd_ready_high", 64'(rd_ready), 64'd1);
        wait_wr(1, "init_write_granted");
        check("init_write_entry", 64'(wlog[0]), {28'd0, 20'h00001, 16'h5555});
        repeat (4) @(negedge clk);

        // Fill the FIFO, then check order of the four writes
        wr_gnt_dly = 8;
        wb = n_wr_gnt;
        for (int k = 0; k < 4; k++) push(20'h00010 + 20'(k), 16'hA000 + 16'(k));
        check("fifo_full_wr_ready", 64'(wr_ready), 64'd0);
        wr_valid = 1'b1;
        wr_addr  = 20'h00099;
        wr_data  = 16'hDEAD;
        repeat (2) @(negedge clk);
        wr_valid = 1'b0;
        wait_wr(wb + 4, "fifo_four_granted");
        for (int k = 0; k < 4; k++)
            check("fifo_order", 64'(wlog[wb + k]), {28'd0, 20'h00010 + 20'(k), 16'hA000 + 16'(k)});
        repeat (12) @(negedge clk);
        check("fifo_push_when_full_ignored", 64'(n_wr_gnt - wb), 64'd4);
        wr_gnt_dly = 2;

        // Single read with slow controller
        rd_gnt_dly = 3;
        rd_lat = 5;
        rd_dout_val = 16'h1234;
        rs0 = n_rsp;
        do_read(20'h80005);
        i = 0;
        while (n_rsp == rs0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        repeat (10) @(negedge clk);
        check("read_r_addr", 64'(last_raddr), 64'h80005);
        check("read_rsp_pulses", 64'(n_rsp - rs0), 64'd1);
        check("read_rsp_data", 64'(last_rsp), 64'h1234);

        // Starvation limit: one pending write against back-to-back reads
        rd_gnt_dly = 2;
        rd_lat = 1;
        wr_gnt_dly = 1;
        rd_dout_val = 16'h0042;
        rd_addr = 20'h00100;
        rd_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (read_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("starve_first_read", 64'(seen), 64'd1);
        rg0 = n_rd_gnt;
        wg0 = n_wr_gnt;
        push(20'h00500, 16'hC0DE);
        i = 0;
        while (n_wr_gnt == wg0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        rd_valid = 1'b0;
        check("starve_reads_before_write", 64'(n_rd_gnt - rg0), 64'd4);
        check("starve_write_entry", 64'(wlog[wg0]), {28'd0, 20'h00500, 16'hC0DE});
        repeat (3) @(negedge clk);
        check("starve_cnt_cleared", 64'(dut.r_starve_cnt), 64'd0);
        repeat (15) @(negedge clk);

        // Held write grant: one pop, no new request until grant falls
        wr_gnt_dly = 2;
        wr_hold = 6;
        wg0 = n_wr_gnt;
        st0 = n_stale;
        push(20'h00200, 16'hBEEF);
        push(20'h00201, 16'hBEF0);
        wait_wr(wg0 + 2, "hold_both_granted");
        check("hold_first",  64'(wlog[wg0]),     {28'd0, 20'h00200, 16'hBEEF});
        check("hold_second", 64'(wlog[wg0 + 1]), {28'd0, 20'h00201, 16'hBEF0});
        check("hold_no_req_while_gnt", 64'(n_stale - st0), 64'd0);
        repeat (12) @(negedge clk);
        check("hold_grant_count", 64'(n_wr_gnt - wg0), 64'd2);
        wr_hold = 1;

        // Reset in the middle of a read with writes queued
        rd_gnt_dly = 2;
        rd_lat = 8;
        rd_dout_val = 16'h7777;
        do_read(20'h00300);
        push(20'h00600, 16'h1111);
        push(20'h00601, 16'h2222);
        repeat (2) @(negedge clk);
        check("midop_raddr_held", 64'(r_addr), 64'h00300);
        ws0 = n_wreq_cyc;
        rs0 = n_rsp;
        wg0 = n_wr_gnt;
        #2 reset_n = 1'b0;
        #1;
        check("midop_async_r_addr", 64'(r_addr), 64'd0);
        check("midop_async_fifo_empty", 64'(dut.r_count), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midop_rd_ready_before_init", 64'(rd_ready), 64'd0);
        check("midop_wr_ready", 64'(wr_ready), 64'd1);
        repeat (25) @(negedge clk);
        check("midop_no_write_req", 64'(n_wreq_cyc - ws0), 64'd0);
        check("midop_no_rsp", 64'(n_rsp - rs0), 64'd0);
        check("midop_no_write_grant", 64'(n_wr_gnt - wg0), 64'd0);

        // Statistics: 3 writes and 2 reads since the last reset
        rd_lat = 2;
        wb = n_wr_gnt;
        rb = n_rd_gnt;
        for (int k = 0; k < 3; k++) push(20'h00700 + 20'(k), 16'h3000 + 16'(k));
        wait_wr(wb + 3, "stats_writes_granted");
        do_read(20'h00800);
        do_read(20'h00801);
        repeat (20) @(negedge clk);
        check("stats_bench_rd_grants", 64'(n_rd_gnt - rb), 64'd2);
`ifdef MY_SDRAM_FRONTEND_STATS_EN
        exp_wr = 16'd3;
        exp_rd = 16'd2;
`else
        exp_wr = 16'd0;
        exp_rd = 16'd0;
`endif
        check("stats_wr", 64'(stat_wr), 64'(exp_wr));
        check("stats_rd", 64'(stat_rd), 64'(exp_rd));

        check("never_both_req", 64'(n_both), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
